fft_iter_frame_scheduler: RTL and testbench
===========================================

// Module: fft_iter_frame_scheduler
// PURPOSE
//  Frame-level sequencer for the iterative in-place FFT core. Runs four phases per frame:
//   - loads N input samples into the shared data RAM at bit-reversed addresses
//   - pulses START to the butterfly control unit, then waits for its completion
//   - unloads N results in natural order over a valid/ready port
//  Owns the RAM port mux: loader/unloader vs. FFT core.
// PARAMETERS
//  N_POINTS  32    FFT length, power of two
//  AddrWL    5     log2(N_POINTS), width of every address/counter
//  TMO_CYC   4096  max cycles in COMPUTE before abort
//  TmoWL     13    width of watchdog counter, >= clog2(TMO_CYC+1)
// PORTS
//  CLK          in   1       clock, all logic on posedge
//  RST_N        in   1       synchronous active-low reset
//  EN           in   1       global enable; 0 = freeze
//  IN_VALID     in   1       input sample valid
//  IN_READY     out  1       scheduler accepts input sample
//  MEM_WE       out  1       RAM write strobe (load phase)
//  MEM_WR_ADDR  out  AddrWL  RAM write address, bit-reversed load index
//  MEM_RD_ADDR  out  AddrWL  RAM read address, unload index
//  MEM_SEL      out  1       1 = RAM port owned by FFT core, 0 = by scheduler
//  CORE_START   out  1       1-cycle start pulse to butterfly control unit
//  CORE_EN      out  1       enable to butterfly control unit
//  CORE_DONE    in   1       1-cycle completion pulse from core
//  OUT_VALID    out  1       RAM read data valid for current MEM_RD_ADDR
//  OUT_READY    in   1       downstream accepts output sample
//  OUT_LAST     out  1       marks sample N-1 (qualified by OUT_VALID)
//  BUSY         out  1       state != IDLE
//  FRAME_DONE   out  1       1-cycle pulse after last output handshake
//  TMO_ERR      out  1       sticky watchdog error; cleared by RST_N only
// BEHAVIOUR
//  Reset: RST_N=0 at posedge -> state IDLE, all counters 0.
//   All outputs 0 (MEM_SEL=0, TMO_ERR=0). Reset mid-frame aborts immediately; no flush.
//  States: IDLE, LOAD, KICK, COMPUTE, UNLOAD_RD, UNLOAD_OUT.
//  EN=0: state, counters and watchdog hold. IN_READY, MEM_WE, CORE_START, OUT_VALID,
//   FRAME_DONE forced 0. CORE_EN=0.
//  IDLE -> LOAD when EN=1.
//  LOAD:
//   - IN_READY=1; MEM_WE = IN_VALID & IN_READY
//   - MEM_WR_ADDR = bitrev(ld_cnt), combinational
//   - each handshake increments ld_cnt
//   - handshake with ld_cnt=N-1 -> ld_cnt wraps to 0, next state KICK
//  KICK: CORE_START=1, MEM_SEL=1 for exactly one cycle -> COMPUTE; watchdog cleared.
//  COMPUTE:
//   - MEM_SEL=1, CORE_EN=EN; watchdog +1 per enabled cycle
//   - CORE_DONE=1 -> UNLOAD_RD (done wins if same cycle as timeout)
//   - watchdog reaches TMO_CYC -> TMO_ERR=1, state IDLE
//   - CORE_DONE outside COMPUTE is ignored
//  UNLOAD (1-cycle RAM read latency; 1 sample per 2 cycles):
//   - UNLOAD_RD: MEM_RD_ADDR=rd_cnt, OUT_VALID=0 -> UNLOAD_OUT
//   - UNLOAD_OUT: OUT_VALID=1, MEM_RD_ADDR held; OUT_LAST=(rd_cnt==N-1)
//   - OUT_READY=0: stay, data stable
//   - OUT_READY=1, rd_cnt<N-1: rd_cnt+1 -> UNLOAD_RD
//   - OUT_READY=1, rd_cnt=N-1: rd_cnt=0; FRAME_DONE pulses next cycle
//   - after last handshake -> LOAD if EN=1, else IDLE
//  MEM_SEL=0 in all states except KICK/COMPUTE. Input never accepted outside LOAD.
//  All counters wrap modulo N_POINTS. No arithmetic wider than AddrWL / TmoWL.
// TESTING
//  T1 reset: RST_N=0 two cycles in mid-LOAD (ld_cnt=7) -> all outputs 0, IDLE; next load starts at addr 0
//  T2 load order, N=32, IN_VALID=1 always: MEM_WR_ADDR = 0,16,8,24,4,... over 32 cycles;
//     CORE_START high exactly 1 cycle, the cycle after the 32nd write
//  T3 backpressure: OUT_READY low 5 cycles on sample 3 -> OUT_VALID stays 1, MEM_RD_ADDR=3 stable;
//     OUT_LAST only on addr 31; FRAME_DONE one cycle after that handshake
//  T4 watchdog, TMO_CYC=16: withhold CORE_DONE -> TMO_ERR=1 after 16 COMPUTE cycles, IDLE, MEM_SEL=0;
//     a later CORE_DONE has no effect
//  T5 EN gating: EN=0 for 10 cycles mid-COMPUTE and mid-UNLOAD -> watchdog/counters frozen, strobes 0,
//     frame resumes and completes correctly
//  T6 back-to-back: two frames with EN=1 -> LOAD re-entered directly after FRAME_DONE,
//     IN_VALID-to-FRAME_DONE order preserved

Source files
------------

// File: rtl/fft_iter_frame_scheduler_if.sv
// rtl/fft_iter_frame_scheduler_if.sv - handshake, RAM-mux and core-control bundle for the FFT frame scheduler
interface fft_iter_frame_scheduler_if #(
  parameter int AddrWL = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [AddrWL-1:0] mem_wr_addr;
  logic [AddrWL-1:0] mem_rd_addr;
  logic              mem_sel;
  logic              core_start;
  logic              core_en;
  logic              core_done;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              frame_done;
  logic              tmo_err;

  // scheduler side
  modport master (
    input  in_valid, core_done, out_ready,
    output in_ready, mem_we, mem_wr_addr, mem_rd_addr, mem_sel,
           core_start, core_en, out_valid, out_last, busy, frame_done, tmo_err
  );

  // environment side: sample source, FFT core and result sink
  modport slave (
    output in_valid, core_done, out_ready,
    input  in_ready, mem_we, mem_wr_addr, mem_rd_addr, mem_sel,
           core_start, core_en, out_valid, out_last, busy, frame_done, tmo_err
  );
endinterface

// File: rtl/fft_iter_frame_scheduler.sv
// rtl/fft_iter_frame_scheduler.sv - frame sequencer for the iterative in-place FFT: load, kick, compute, unload
module fft_iter_frame_scheduler #(
  parameter int N_POINTS = 32,
  parameter int AddrWL   = 5,
  parameter int TMO_CYC  = 4096,
  parameter int TmoWL    = 13
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  fft_iter_frame_scheduler_if.master   bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_KICK       = 3'd2;
  localparam logic [2:0] S_COMPUTE    = 3'd3;
  localparam logic [2:0] S_UNLOAD_RD  = 3'd4;
  localparam logic [2:0] S_UNLOAD_OUT = 3'd5;

  localparam logic [AddrWL-1:0] CNT_LAST = AddrWL'(N_POINTS - 1);
  // Watchdog fires on the enabled COMPUTE cycle that would make the count reach TMO_CYC.
  localparam logic [TmoWL-1:0]  TMO_LAST = TmoWL'(TMO_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [AddrWL-1:0] ld_cnt_q, ld_cnt_d;
  logic [AddrWL-1:0] rd_cnt_q, rd_cnt_d;
  logic [TmoWL-1:0]  wdog_q, wdog_d;
  logic              tmo_err_q, tmo_err_d;
  logic              frame_done_q, frame_done_d;

  logic              in_ready_w;
  logic              out_valid_w;
  logic              in_hs;
  logic              out_hs;

  // Loading at bit-reversed addresses lets the in-place core emit natural order.
  function automatic logic [AddrWL-1:0] bit_reverse(input logic [AddrWL-1:0] idx);
    logic [AddrWL-1:0] rev;
    rev = '0;
    for (int i = 0; i < AddrWL; i++) begin
      rev[i] = idx[AddrWL-1-i];
    end
    return rev;
  endfunction

  assign in_ready_w  = en_i & (state_q == S_LOAD);
  assign out_valid_w = en_i & (state_q == S_UNLOAD_OUT);
  assign in_hs       = in_ready_w & bus.in_valid;
  assign out_hs      = out_valid_w & bus.out_ready;

  assign bus.in_ready    = in_ready_w;
  assign bus.mem_we      = in_hs;
  assign bus.mem_wr_addr = bit_reverse(ld_cnt_q);
  assign bus.mem_rd_addr = rd_cnt_q;
  // The core owns the RAM only while it is being kicked or is computing.
  assign bus.mem_sel     = (state_q == S_KICK) | (state_q == S_COMPUTE);
  assign bus.core_start  = en_i & (state_q == S_KICK);
  assign bus.core_en     = en_i & (state_q == S_COMPUTE);
  assign bus.out_valid   = out_valid_w;
  assign bus.out_last    = out_valid_w & (rd_cnt_q == CNT_LAST);
  assign bus.busy        = (state_q != S_IDLE);
  // A pending done pulse is held through EN=0 and delivered once enabled again.
  assign bus.frame_done  = en_i & frame_done_q;
  assign bus.tmo_err     = tmo_err_q;

  // Next-state and counter update; everything holds while EN is low.
  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wdog_d       = wdog_q;
    tmo_err_d    = tmo_err_q;
    frame_done_d = frame_done_q;
    if (en_i) begin
      frame_done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (in_hs) begin
            if (ld_cnt_q == CNT_LAST) begin
              ld_cnt_d = '0;
              state_d  = S_KICK;
            end else begin
              ld_cnt_d = ld_cnt_q + 1'b1;
            end
          end
        end
        S_KICK: begin
          wdog_d  = '0;
          state_d = S_COMPUTE;
        end
        S_COMPUTE: begin
          // Completion is checked first so it wins over a simultaneous timeout.
          if (bus.core_done) begin
            state_d = S_UNLOAD_RD;
          end else if (wdog_q == TMO_LAST) begin
            wdog_d    = wdog_q + 1'b1;
            tmo_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        S_UNLOAD_RD: begin
          state_d = S_UNLOAD_OUT;
        end
        S_UNLOAD_OUT: begin
          if (out_hs) begin
            if (rd_cnt_q == CNT_LAST) begin
              rd_cnt_d     = '0;
              frame_done_d = 1'b1;
              state_d      = S_LOAD;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
              state_d  = S_UNLOAD_RD;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      ld_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wdog_q       <= '0;
      tmo_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wdog_q       <= wdog_d;
      tmo_err_q    <= tmo_err_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fft_iter_frame_scheduler.sv
// tb/tb_fft_iter_frame_scheduler.sv - randomized self-checking bench for the FFT frame scheduler
module tb_fft_iter_frame_scheduler;
  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] ram [N];
  logic [15:0] rd_data;
  logic [15:0] in_q [N];
  logic [15:0] in_data;

  always #5 clk = ~clk;

  fft_iter_frame_scheduler_if #(.AddrWL(AW)) bus ();

  fft_iter_frame_scheduler #(
    .N_POINTS(N), .AddrWL(AW), .TMO_CYC(TMO), .TmoWL(5)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .en_i   (en),
    .bus    (bus)
  );

  // Shared data RAM with one cycle of read latency
  always @(posedge clk) rd_data <= ram[bus.mem_rd_addr];

  function automatic int bitrev_ref(input int k);
    int r;
    int x;
    r = 0;
    x = k;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic do_reset(input string tag);
    logic [AW*2+12:0] outs;
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; bus.in_valid = 1'b1; bus.core_done = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    outs = {bus.in_ready, bus.mem_we, bus.mem_wr_addr, bus.mem_rd_addr, bus.mem_sel, bus.core_start,
            bus.core_en, bus.out_valid, bus.out_last, bus.busy, bus.frame_done, bus.tmo_err};
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL %s reset_outputs got %h exp 0", tag, outs); end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input int n, input int pct, output int span);
    int k, budget, cyc, first;
    k = 0; budget = 1000; cyc = 0; first = 0; span = 0;
    while (k < n && budget > 0) begin
      budget--;
      @(negedge clk);
      en = 1'b1; bus.out_ready = 1'b0; bus.core_done = 1'b0;
      bus.in_valid = ($urandom_range(0, 99) < pct);
      in_data = 16'($urandom);
      #1;
      n_checks++; if ({bus.mem_sel, bus.core_start, bus.out_valid, bus.frame_done} !== 4'b0) begin n_fail++; $display("FAIL %s load_strobes got %b exp 0000", tag, {bus.mem_sel, bus.core_start, bus.out_valid, bus.frame_done}); end
      if (bus.mem_we) begin
        n_checks++; if (int'(bus.mem_wr_addr) !== bitrev_ref(k)) begin n_fail++; $display("FAIL %s wr_addr k=%0d got %0d exp %0d", tag, k, bus.mem_wr_addr, bitrev_ref(k)); end
        ram[bus.mem_wr_addr] = in_data;
        in_q[k] = in_data;
        if (k == 0) first = cyc;
        span = cyc - first + 1;
        k++;
      end
      cyc++;
    end
    n_checks++; if (k !== n) begin n_fail++; $display("FAIL %s load_timeout got %0d writes exp %0d", tag, k, n); end
  endtask

  task automatic do_kick(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    n_checks++; if ({bus.core_start, bus.mem_sel, bus.in_ready, bus.mem_we, bus.core_en} !== 5'b11000) begin n_fail++; $display("FAIL %s kick got %b exp 11000", tag, {bus.core_start, bus.mem_sel, bus.in_ready, bus.mem_we, bus.core_en}); end
  endtask

  task automatic do_compute(input string tag, input int delay, input int gate_at);
    int  c;
    bit  gated;
    c = 0; gated = 1'b0;
    while (c <= delay) begin
      if (c == gate_at && !gated) begin
        gated = 1'b1;
        repeat (10) begin
          @(negedge clk);
          en = 1'b0; bus.core_done = 1'b0; bus.in_valid = 1'b1;
          #1;
          n_checks++; if ({bus.core_en, bus.core_start, bus.in_ready, bus.out_valid, bus.frame_done, bus.mem_sel, bus.busy, bus.tmo_err} !== 8'b00000110) begin n_fail++; $display("FAIL %s compute_gated got %b exp 00000110", tag, {bus.core_en, bus.core_start, bus.in_ready, bus.out_valid, bus.frame_done, bus.mem_sel, bus.busy, bus.tmo_err}); end
        end
      end
      @(negedge clk);
      en = 1'b1; bus.in_valid = 1'b1;
      bus.core_done = (c == delay);
      #1;
      n_checks++; if ({bus.core_en, bus.mem_sel, bus.core_start, bus.tmo_err, bus.in_ready} !== 5'b11000) begin n_fail++; $display("FAIL %s compute c=%0d got %b exp 11000", tag, c, {bus.core_en, bus.mem_sel, bus.core_start, bus.tmo_err, bus.in_ready}); end
      c++;
    end
  endtask

  task automatic do_unload(input string tag, input int ready_pct, input int stall_idx, input int gate_idx);
    int idx, budget, stall_left;
    bit gated;
    idx = 0; budget = 2000; stall_left = 5; gated = 1'b0;
    while (idx < N && budget > 0) begin
      budget--;
      if (idx == gate_idx && !gated) begin
        gated = 1'b1;
        repeat (10) begin
          @(negedge clk);
          en = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.core_done = 1'b0;
          #1;
          n_checks++; if ({bus.out_valid, bus.out_last, bus.frame_done, bus.in_ready, bus.mem_we, bus.core_start, bus.core_en} !== 7'b0) begin n_fail++; $display("FAIL %s unload_gated got %b exp 0000000", tag, {bus.out_valid, bus.out_last, bus.frame_done, bus.in_ready, bus.mem_we, bus.core_start, bus.core_en}); end
          n_checks++; if (int'(bus.mem_rd_addr) !== idx) begin n_fail++; $display("FAIL %s unload_gated_addr got %0d exp %0d", tag, bus.mem_rd_addr, idx); end
        end
      end
      @(negedge clk);
      en = 1'b1; bus.core_done = 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = (idx == stall_idx && stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      #1;
      n_checks++; if ({bus.in_ready, bus.mem_we, bus.mem_sel, bus.frame_done} !== 4'b0) begin n_fail++; $display("FAIL %s unload_strobes got %b exp 0000", tag, {bus.in_ready, bus.mem_we, bus.mem_sel, bus.frame_done}); end
      if (idx == stall_idx && stall_left > 0 && stall_left < 5) begin
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL %s stall_valid got %b exp 1", tag, bus.out_valid); end
      end
      if (bus.out_valid) begin
        n_checks++; if (int'(bus.mem_rd_addr) !== idx) begin n_fail++; $display("FAIL %s rd_addr got %0d exp %0d", tag, bus.mem_rd_addr, idx); end
        n_checks++; if (bus.out_last !== (idx == N - 1)) begin n_fail++; $display("FAIL %s out_last idx=%0d got %b exp %b", tag, idx, bus.out_last, (idx == N - 1)); end
        n_checks++; if (rd_data !== in_q[bitrev_ref(idx)]) begin n_fail++; $display("FAIL %s out_data idx=%0d got %h exp %h", tag, idx, rd_data, in_q[bitrev_ref(idx)]); end
        if (idx == stall_idx && stall_left > 0) stall_left--;
        else if (bus.out_ready) idx++;
      end else begin
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL %s out_last_idle got %b exp 0", tag, bus.out_last); end
      end
    end
    n_checks++; if (idx !== N) begin n_fail++; $display("FAIL %s unload_timeout got %0d samples exp %0d", tag, idx, N); end
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_checks++; if ({bus.frame_done, bus.in_ready, bus.busy, bus.out_valid} !== 4'b1110) begin n_fail++; $display("FAIL %s frame_done got %b exp 1110", tag, {bus.frame_done, bus.in_ready, bus.busy, bus.out_valid}); end
  endtask

  task automatic test_reset();
    int span;
    do_reset("t1_por");
    do_load("t1_part", 7, 100, span);
    do_reset("t1_mid");
    do_load("t1_load", N, 60, span);
    do_kick("t1");
    do_compute("t1", 2, -1);
    do_unload("t1", 100, -1, -1);
  endtask

  task automatic test_load_order();
    int span;
    do_reset("t2");
    do_load("t2_load", N, 100, span);
    n_checks++; if (span !== N) begin n_fail++; $display("FAIL t2 load_span got %0d exp %0d", span, N); end
    do_kick("t2");
    do_compute("t2", TMO - 1, -1);
    do_unload("t2", 70, -1, -1);
  endtask

  task automatic test_backpressure();
    int span;
    do_reset("t3");
    do_load("t3_load", N, 80, span);
    do_kick("t3");
    do_compute("t3", 5, -1);
    do_unload("t3", 100, 3, -1);
  endtask

  task automatic test_watchdog();
    int span;
    do_reset("t4");
    do_load("t4_load", N, 70, span);
    do_kick("t4");
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      bus.core_done = 1'b0; bus.in_valid = 1'b0;
      #1;
      n_checks++; if ({bus.tmo_err, bus.core_en, bus.mem_sel} !== 3'b011) begin n_fail++; $display("FAIL t4 pre_timeout c=%0d got %b exp 011", c, {bus.tmo_err, bus.core_en, bus.mem_sel}); end
    end
    @(negedge clk);
    bus.core_done = 1'b1;
    #1;
    n_checks++; if ({bus.tmo_err, bus.busy, bus.mem_sel, bus.core_en} !== 4'b1000) begin n_fail++; $display("FAIL t4 timeout got %b exp 1000", {bus.tmo_err, bus.busy, bus.mem_sel, bus.core_en}); end
    @(negedge clk);
    bus.core_done = 1'b0;
    #1;
    n_checks++; if ({bus.tmo_err, bus.mem_sel, bus.out_valid, bus.core_start, bus.in_ready} !== 5'b10001) begin n_fail++; $display("FAIL t4 late_done got %b exp 10001", {bus.tmo_err, bus.mem_sel, bus.out_valid, bus.core_start, bus.in_ready}); end
  endtask

  task automatic test_en_gating();
    int span;
    do_reset("t5");
    n_checks++; if (bus.tmo_err !== 1'b0) begin n_fail++; $display("FAIL t5 tmo_cleared got %b exp 0", bus.tmo_err); end
    do_load("t5_load", N, 50, span);
    do_kick("t5");
    do_compute("t5", 12, 3);
    do_unload("t5", 60, -1, 10);
  endtask

  task automatic test_back_to_back();
    int span;
    do_reset("t6");
    for (int f = 0; f < 2; f++) begin
      do_load("t6_load", N, int'($urandom_range(40, 100)), span);
      do_kick("t6");
      do_compute("t6", int'($urandom_range(0, TMO - 1)), -1);
      do_unload("t6", int'($urandom_range(30, 100)), -1, -1);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    bus.in_valid = 1'b0; bus.core_done = 1'b0; bus.out_ready = 1'b0;
    in_data = '0;
    for (int i = 0; i < N; i++) begin ram[i] = '0; in_q[i] = '0; end
    test_reset();
    test_load_order();
    test_backpressure();
    test_watchdog();
    test_en_gating();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got stuck exp completion");
    $fatal(1, "bench did not complete");
  end
endmodule
